// File: rtl/code_conv_arbiter_pkg.sv
// code_conv_arbiter_pkg
// Shared definitions for the binary/gray converter arbiter slice:
//   - conversion mode encodings carried on reqN_mode / rsp_mode
//   - default code and grant-counter widths
//   - requester identifier enum used by the round-robin pointer
package code_conv_arbiter_pkg;

  localparam int DEFAULT_DATA_W = 4;
  localparam int DEFAULT_CNT_W  = 8;

  localparam logic CONV_BIN2GRAY = 1'b0;
  localparam logic CONV_GRAY2BIN = 1'b1;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

endpackage

// File: rtl/code_conv_arbiter_convert.sv
// code_convert
// Purely combinational binary<->gray converter shared by both requesters.
// Ports:
//   din  [DATA_W-1:0]  input code
//   mode               CONV_BIN2GRAY or CONV_GRAY2BIN
//   dout [DATA_W-1:0]  converted code, same width as din
module code_convert
  import code_conv_arbiter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] din,
  input  logic              mode,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] gray;
  logic [DATA_W-1:0] bin;

  assign gray = din ^ (din >> 1);

  // Gray->binary: each binary bit is the XOR of all gray bits at or above it,
  // so a reduction XOR of the shifted input avoids a bit-serial chain.
  always_comb begin
    bin = '0;
    for (int i = 0; i < DATA_W; i++) begin
      bin[i] = ^(din >> i);
    end
  end

  always_comb begin
    dout = gray;
    case (mode)
      CONV_BIN2GRAY: dout = gray;
      CONV_GRAY2BIN: dout = bin;
      default:       dout = gray;
    endcase
  end

endmodule

// File: rtl/code_conv_arbiter.sv
// code_conv_arbiter
// Two requesters share one code converter through valid/ready handshakes.
// Round-robin arbitration, one registered response port tagged with the
// requester id, and per-requester saturating grant counters for debug.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/ready/data/mode requester N handshake, code and direction
//   rsp_valid/ready            response handshake
//   rsp_data/id/mode           converted code, owning requester, direction
//   cnt_clr                    synchronous clear of both grant counters
//   grant_cnt0/1               saturating accepted-transaction counters
module code_conv_arbiter
  import code_conv_arbiter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_mode,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_mode,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              rsp_mode,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  req_id_e           last_grant;
  req_id_e           grant_id;
  logic              grant_valid;
  logic              can_load;
  logic              accept;
  logic [DATA_W-1:0] sel_data;
  logic              sel_mode;
  logic [DATA_W-1:0] conv_data;

  assign can_load = !rsp_valid || rsp_ready;

  // Round-robin grant: a lone requester always wins; on contention the one
  // that did not win last time goes next.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = (last_grant == REQ0) ? REQ1 : REQ0;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = REQ0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = REQ1;
    end
  end

  assign req0_ready = can_load && grant_valid && (grant_id == REQ0);
  assign req1_ready = can_load && grant_valid && (grant_id == REQ1);
  assign accept     = req0_ready || req1_ready;

  assign sel_data = (grant_id == REQ1) ? req1_data : req0_data;
  assign sel_mode = (grant_id == REQ1) ? req1_mode : req0_mode;

  code_convert #(
    .DATA_W(DATA_W)
  ) u_convert (
    .din (sel_data),
    .mode(sel_mode),
    .dout(conv_data)
  );

  // Response register: reloads on accept (including the drain+accept cycle),
  // drops valid on a drain with nothing new, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_mode  <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= conv_data;
      rsp_id    <= grant_id;
      rsp_mode  <= sel_mode;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Priority pointer only moves on an accept. Resetting it to REQ1 makes
  // requester 0 win the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ1;
    end else if (accept) begin
      last_grant <= grant_id;
    end
  end

  // Saturating grant counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (cnt_clr) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != CNT_MAX) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req1_ready && grant_cnt1 != CNT_MAX) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_code_conv_arbiter.sv
// tb_code_conv_arbiter
// Scoreboard bench: a reference model evaluates each cycle's inputs just
// before the clock edge, checks readys/valid/counters, and queues expected
// responses; a monitor compares every presented response against the queue.
module tb_code_conv_arbiter;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              id;
    logic              mode;
  } rsp_t;

  logic              clk;
  logic              rst_n;
  logic              req0_valid, req0_ready, req0_mode;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid, req1_ready, req1_mode;
  logic [DATA_W-1:0] req1_data;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_mode;
  logic [DATA_W-1:0] rsp_data;
  logic              cnt_clr;
  logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;

  int checks   = 0;
  int failures = 0;

  rsp_t exp_q[$];

  // reference model state (state after the most recent clock edge)
  logic m_valid = 1'b0;
  int   m_last  = 1;
  int   m_cnt0  = 0;
  int   m_cnt1  = 0;
  logic m_acc0  = 1'b0;
  logic m_acc1  = 1'b0;

  code_conv_arbiter #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_data (req0_data),
    .req0_mode (req0_mode),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_data (req1_data),
    .req1_mode (req1_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_mode  (rsp_mode),
    .cnt_clr   (cnt_clr),
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DATA_W-1:0] ref_b2g(input logic [DATA_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Inverse by search: the binary value whose gray code equals g.
  function automatic logic [DATA_W-1:0] ref_g2b(input logic [DATA_W-1:0] g);
    logic [DATA_W-1:0] cand;
    for (int b = 0; b < (1 << DATA_W); b++) begin
      cand = DATA_W'(b);
      if (ref_b2g(cand) == g) return cand;
    end
    return '0;
  endfunction

  function automatic logic [DATA_W-1:0] ref_conv(input logic [DATA_W-1:0] d, input logic m);
    return m ? ref_g2b(d) : ref_b2g(d);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs shortly after the rising edge.
  task automatic applyStimulus(input logic v0, input logic [DATA_W-1:0] d0, input logic md0,
                               input logic v1, input logic [DATA_W-1:0] d1, input logic md1,
                               input logic rr, input logic clr);
    @(posedge clk);
    #2;
    req0_valid = v0; req0_data = d0; req0_mode = md0;
    req1_valid = v1; req1_data = d1; req1_mode = md1;
    rsp_ready  = rr; cnt_clr = clr;
    #1;
  endtask

  // Reference model: checks state left by the previous edge, then predicts
  // what the coming edge does with the inputs currently applied.
  always @(negedge clk) begin
    int   winner;
    logic any_req, can_load, acc;
    if (!rst_n) begin
      m_valid = 1'b0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
      m_acc0 = 1'b0; m_acc1 = 1'b0;
      exp_q.delete();
    end else begin
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      checkOutput("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt0));
      checkOutput("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt1));
      any_req  = req0_valid || req1_valid;
      can_load = !m_valid || rsp_ready;
      if (req0_valid && req1_valid) winner = 1 - m_last;
      else if (req1_valid)          winner = 1;
      else                          winner = 0;
      acc = any_req && can_load;
      checkOutput("req0_ready", 32'(req0_ready), 32'(acc && winner == 0));
      checkOutput("req1_ready", 32'(req1_ready), 32'(acc && winner == 1));
      m_acc0 = acc && winner == 0;
      m_acc1 = acc && winner == 1;
      if (acc) begin
        if (winner == 0) exp_q.push_back('{ref_conv(req0_data, req0_mode), 1'b0, req0_mode});
        else             exp_q.push_back('{ref_conv(req1_data, req1_mode), 1'b1, req1_mode});
        m_last  = winner;
        m_valid = 1'b1;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
      if (cnt_clr) begin
        m_cnt0 = 0; m_cnt1 = 0;
      end else if (acc) begin
        if (winner == 0 && m_cnt0 < CNT_MAX) m_cnt0++;
        if (winner == 1 && m_cnt1 < CNT_MAX) m_cnt1++;
      end
    end
  end

  // Monitor: any presented response must match the oldest outstanding one;
  // it is retired only when downstream consumes it.
  always @(negedge clk) begin
    rsp_t exp;
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("rsp_unexpected", 32'(rsp_valid), 32'(0));
      end else begin
        exp = exp_q[0];
        checkOutput("rsp_data", 32'(rsp_data), 32'(exp.data));
        checkOutput("rsp_id",   32'(rsp_id),   32'(exp.id));
        checkOutput("rsp_mode", 32'(rsp_mode), 32'(exp.mode));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_mode = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_mode = 1'b0;
    rsp_ready = 1'b0; cnt_clr = 1'b0;
    #12;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("reset_rsp_data",  32'(rsp_data),  32'(0));
    checkOutput("reset_rsp_id",    32'(rsp_id),    32'(0));
    checkOutput("reset_rsp_mode",  32'(rsp_mode),  32'(0));
    checkOutput("reset_cnt0",      32'(grant_cnt0), 32'(0));
    checkOutput("reset_cnt1",      32'(grant_cnt1), 32'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;

    // single transactions from each requester
    applyStimulus(1, 4'b1011, 0, 0, 4'b0000, 0, 1, 0);
    checkOutput("first_req0_ready", 32'(req0_ready), 32'(1));
    applyStimulus(0, 4'b0000, 0, 1, 4'b1110, 1, 1, 0);
    checkOutput("first_rsp_data", 32'(rsp_data), 32'(4'b1110));
    checkOutput("first_rsp_id",   32'(rsp_id),   32'(0));
    checkOutput("first_cnt0",     32'(grant_cnt0), 32'(1));
    applyStimulus(0, 4'b0000, 0, 1, 4'b0110, 1, 1, 0);
    checkOutput("g2b_1110", 32'(rsp_data), 32'(4'b1011));
    checkOutput("g2b_id",   32'(rsp_id),   32'(1));
    applyStimulus(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
    checkOutput("g2b_0110", 32'(rsp_data), 32'(4'b0100));

    // continuous contention: grants alternate, counters saturate at CNT_MAX
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1, DATA_W'($urandom), 1'($urandom), 1, 4'b0110, 0, 1, 0);
    end
    applyStimulus(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
    checkOutput("contend_cnt0", 32'(grant_cnt0), 32'(CNT_MAX));
    checkOutput("contend_cnt1", 32'(grant_cnt1), 32'(CNT_MAX));

    // back-pressure for three cycles, then drain and reload together
    applyStimulus(1, 4'b0011, 0, 0, 4'b0000, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 4'b1001, 1, 0, 4'b0000, 0, 0, 0);
      checkOutput("bp_req0_ready", 32'(req0_ready), 32'(0));
    end
    applyStimulus(1, 4'b1001, 1, 0, 4'b0000, 0, 1, 0);
    checkOutput("bp_release_ready", 32'(req0_ready), 32'(1));
    applyStimulus(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
    checkOutput("bp_reload_data", 32'(rsp_data), 32'(4'b1110));

    // clear in the same cycle as an accept
    applyStimulus(1, 4'b0101, 0, 0, 4'b0000, 0, 1, 1);
    applyStimulus(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
    checkOutput("clr_cnt0", 32'(grant_cnt0), 32'(0));
    checkOutput("clr_cnt1", 32'(grant_cnt1), 32'(0));

    // randomized traffic honouring the hold-while-pending rule
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #2;
      if (!(req0_valid && !m_acc0)) begin
        req0_valid = ($urandom_range(0, 99) < 60);
        req0_data  = DATA_W'($urandom);
        req0_mode  = 1'($urandom);
      end
      if (!(req1_valid && !m_acc1)) begin
        req1_valid = ($urandom_range(0, 99) < 60);
        req1_data  = DATA_W'($urandom);
        req1_mode  = 1'($urandom);
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      cnt_clr   = ($urandom_range(0, 99) < 5);
    end

    // reset while a response is held
    applyStimulus(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
    applyStimulus(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
    applyStimulus(1, 4'b0111, 0, 0, 4'b0000, 0, 0, 0);
    applyStimulus(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    checkOutput("pre_reset_valid", 32'(rsp_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(rsp_valid), 32'(0));
    checkOutput("async_rst_cnt0",  32'(grant_cnt0), 32'(0));
    checkOutput("async_rst_data",  32'(rsp_data),  32'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(1, 4'b0001, 0, 1, 4'b0010, 0, 1, 0);
    checkOutput("post_rst_r0", 32'(req0_ready), 32'(1));
    checkOutput("post_rst_r1", 32'(req1_ready), 32'(0));

    // drain everything
    for (int c = 0; c < 3; c++) applyStimulus(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
    @(negedge clk);
    #1;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
